// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the serial sequence recognizer: frames each word with recognizer reset,
// shifts it out one bit per clock and returns the sampled F. Optional bit counters: SERIALIZER_BITCOUNT_EN.
module bit_stream_serializer #(
  parameter int WIDTH      = 8,
  parameter int LSB_FIRST  = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_x,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             frame_rst,
  input  logic             f_in,
  output logic             result,
  output logic             result_vld
`ifdef SERIALIZER_BITCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] ones_cnt,
  output logic [$clog2(WIDTH+1)-1:0] zeros_cnt
`endif
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [BW-1:0]    bcnt_q;
  logic [GW-1:0]    gcnt_q;
  logic             in_ready_q, ser_x_q, bit_valid_q, last_bit_q, frame_rst_q;
  logic             result_q, result_vld_q;

  logic             accept;
  logic             next_bit_d;
  logic [WIDTH-1:0] sreg_d;

  // in_ready_q is only high in IDLE/DONE, so accept implies one of those states
  assign accept     = in_valid & in_ready_q;
  assign next_bit_d = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[WIDTH-1];
  assign sreg_d     = (LSB_FIRST != 0) ? (sreg_q >> 1) : (sreg_q << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bcnt_q       <= '0;
      gcnt_q       <= '0;
      in_ready_q   <= 1'b1;
      ser_x_q      <= 1'b0;
      bit_valid_q  <= 1'b0;
      last_bit_q   <= 1'b0;
      frame_rst_q  <= 1'b1;
      result_q     <= 1'b0;
      result_vld_q <= 1'b0;
    end else begin
      result_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= CLEAR;
            sreg_q      <= in_data;
            gcnt_q      <= GW'(GAP_CYCLES - 1);
            in_ready_q  <= 1'b0;
            frame_rst_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (gcnt_q == '0) begin
            state_q     <= SHIFT;
            frame_rst_q <= 1'b0;
            bit_valid_q <= 1'b1;
            last_bit_q  <= 1'b0;
            ser_x_q     <= next_bit_d;
            sreg_q      <= sreg_d;
            bcnt_q      <= BW'(WIDTH - 1);
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
          end
        end
        SHIFT: begin
          // bcnt_q counts bits still to come after the one now on ser_x
          if (bcnt_q == '0) begin
            state_q     <= DONE;
            bit_valid_q <= 1'b0;
            last_bit_q  <= 1'b0;
            ser_x_q     <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            ser_x_q    <= next_bit_d;
            sreg_q     <= sreg_d;
            bcnt_q     <= bcnt_q - 1'b1;
            last_bit_q <= (bcnt_q == BW'(1));
          end
        end
        DONE: begin
          result_q     <= f_in;
          result_vld_q <= 1'b1;
          if (accept) begin
            state_q     <= CLEAR;
            sreg_q      <= in_data;
            gcnt_q      <= GW'(GAP_CYCLES - 1);
            in_ready_q  <= 1'b0;
            frame_rst_q <= 1'b1;
          end else begin
            state_q     <= IDLE;
            frame_rst_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIALIZER_BITCOUNT_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] ones_q, zeros_q;
  logic          shift_en;

  // every edge that puts a new word bit on ser_x
  assign shift_en = ((state_q == CLEAR) && (gcnt_q == '0)) ||
                    ((state_q == SHIFT) && (bcnt_q != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= '0;
      zeros_q <= '0;
    end else if (accept) begin
      ones_q  <= '0;
      zeros_q <= '0;
    end else if (shift_en) begin
      if (next_bit_d) ones_q  <= ones_q + 1'b1;
      else            zeros_q <= zeros_q + 1'b1;
    end
  end

  assign ones_cnt  = ones_q;
  assign zeros_cnt = zeros_q;
`endif

  assign in_ready   = in_ready_q;
  assign ser_x      = ser_x_q;
  assign bit_valid  = bit_valid_q;
  assign last_bit   = last_bit_q;
  assign frame_rst  = frame_rst_q;
  assign result     = result_q;
  assign result_vld = result_vld_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: random and directed words, a behavioural recognizer
// stand-in on the serial side, and a second LSB-first instance with a longer gap.
module tb_bit_stream_serializer;
  localparam int W    = 8;
  localparam int GAP  = 1;
  localparam int LGAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready, ser_x, bit_valid, last_bit, frame_rst, f_in, result, result_vld;

  logic [W-1:0] l_data;
  logic         l_valid;
  logic         l_in_ready, l_ser_x, l_bit_valid, l_last_bit, l_frame_rst, l_result, l_result_vld;
  logic         l_f;

`ifdef SERIALIZER_BITCOUNT_EN
  logic [$clog2(W+1)-1:0] ones_cnt, zeros_cnt, l_ones_cnt, l_zeros_cnt;
`endif

  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(0), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_x(ser_x), .bit_valid(bit_valid), .last_bit(last_bit), .frame_rst(frame_rst),
    .f_in(f_in), .result(result), .result_vld(result_vld)
`ifdef SERIALIZER_BITCOUNT_EN
    , .ones_cnt(ones_cnt), .zeros_cnt(zeros_cnt)
`endif
  );

  bit_stream_serializer #(.WIDTH(W), .LSB_FIRST(1), .GAP_CYCLES(LGAP)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_in_ready),
    .ser_x(l_ser_x), .bit_valid(l_bit_valid), .last_bit(l_last_bit), .frame_rst(l_frame_rst),
    .f_in(l_f), .result(l_result), .result_vld(l_result_vld)
`ifdef SERIALIZER_BITCOUNT_EN
    , .ones_cnt(l_ones_cnt), .zeros_cnt(l_zeros_cnt)
`endif
  );

  // Recognizer stand-in: F=1 when ones seen is a multiple of 3 and zeros seen is odd
  int r1;
  bit r0;
  always @(posedge clk) begin
    if (frame_rst) begin
      r1 <= 0;
      r0 <= 1'b0;
    end else if (ser_x) r1 <= (r1 + 1) % 3;
    else r0 <= ~r0;
  end
  assign f_in = (r1 == 0) && r0;
  assign l_f  = 1'b0;

  function automatic logic model_f(input logic [W-1:0] w);
    int ones;
    ones = $countones(w);
    return ((ones % 3) == 0) && (((W - ones) % 2) == 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] w;
    logic         res;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: reassembles serial bits and pops the scoreboard on each result pulse
  logic [W-1:0] got;
  int   nbits   = 0;
  int   rv_last = -1;
  int   rv_prev = -1;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) nbits = 0;
    else begin
      if (bit_valid) begin
        check("frame_rst_low_in_shift", 32'(frame_rst), 32'd0);
        if (nbits == 0 && exp_q.size() > 0)
          check("first_bit_latency", cyc, exp_q[0].acc + GAP);
        check("last_bit", 32'(last_bit), 32'(nbits == W - 1));
        got = {got[W-2:0], ser_x};
        nbits++;
      end
      if (result_vld) begin
        rv_prev = rv_last;
        rv_last = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result_vld: got pulse with empty scoreboard (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 32'(result), 32'(mon_e.res));
          check("ser_sequence", 32'(got), 32'(mon_e.w));
          check("bits_per_word", nbits, W);
          check("result_latency", cyc, mon_e.acc + GAP + W + 1);
        end
        nbits = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    int   n;
    exp_t e;
    n        = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end else begin
      e.w = w;
      e.res = model_f(w);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      step();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic lsb_word(input logic [W-1:0] w);
    int n;
    logic [W-1:0] lg;
    n       = 0;
    lg      = '0;
    l_data  = w;
    l_valid = 1'b1;
    while (!l_in_ready && n < 100) begin
      step();
      n++;
    end
    check("lsb_in_ready", 32'(l_in_ready), 32'd1);
    step();
    l_valid = 1'b0;
    for (int k = 0; k < LGAP; k++) begin
      check("lsb_gap_frame", {30'd0, l_frame_rst, l_bit_valid}, 32'd2);
      step();
    end
    for (int i = 0; i < W; i++) begin
      check("lsb_bit_valid", 32'(l_bit_valid), 32'd1);
      check("lsb_last_bit", 32'(l_last_bit), 32'(i == W - 1));
      if (i == 0) check("lsb_first_bit", 32'(l_ser_x), 32'(w[0]));
      lg[i] = l_ser_x;
      step();
    end
    check("lsb_sequence", 32'(lg), 32'(w));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

  initial begin
    int seen;
    logic [W-1:0] w;
    in_valid = 1'b0;
    in_data  = '0;
    l_valid  = 1'b0;
    l_data   = '0;
    rst      = 1'b1;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_rst", 32'(frame_rst), 32'd1);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_ser_x_last", {30'd0, ser_x, last_bit}, 32'd0);
    check("rst_result", {30'd0, result, result_vld}, 32'd0);
    rst = 1'b0;
    step();

    send(8'b1100_0100); in_valid = 1'b0; drain();
    check("result_c4", 32'(result), 32'd1);
    send(8'b1111_0000); in_valid = 1'b0; drain();
    check("result_f0", 32'(result), 32'd0);
    send(8'b0000_0001); in_valid = 1'b0; drain();
    send(8'h00); in_valid = 1'b0; drain();
    send(8'hFF); in_valid = 1'b0; drain();

    // back-to-back: in_valid held, second word taken in DONE
    send(8'b1100_0100);
    send(8'b0011_1000);
    in_valid = 1'b0;
    drain();
    check("b2b_spacing", rv_last - rv_prev, W + GAP + 1);

    for (int i = 0; i < 40; i++) begin
      send(W'($urandom));
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) step();
      end
    end
    in_valid = 1'b0;
    drain();

    // reset during the 4th shifted bit
    send(8'b1100_0100); in_valid = 1'b0; drain();
    check("result_before_rst", 32'(result), 32'd1);
    send(8'b1010_1010);
    in_valid = 1'b0;
    repeat (3) step();
    check("mid_word_bit_valid", 32'(bit_valid), 32'd1);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_frame_rst", 32'(frame_rst), 32'd1);
    check("midrst_bit_valid", 32'(bit_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      if (result_vld) seen++;
      step();
    end
    check("midrst_no_result_vld", seen, 0);
    send(8'b1100_0100); in_valid = 1'b0; drain();
    check("after_rst_result", 32'(result), 32'd1);

    lsb_word(8'h01);
    for (int i = 0; i < 3; i++) begin
      w = W'($urandom);
      lsb_word(w);
    end

    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
